camera_capture_control: RTL and testbench

Parametrised SPI-domain control block for the camera pipeline. It decodes camera op-codes, holds a run-time programmable crop window with shadow commit, and runs the capture state machine, including optional multi-frame burst and continuous capture. It also drives the image-buffer read address and multiplexes JPEG size, metering and status bytes onto the SPI response bus. It sits between the SPI register interface and the pixel-domain crop/debayer/JPEG chain, which synchronises `capture_active_out` itself.

---
 rtl/camera_capture_control.sv | 212 +++++++++++++++++++++
 tb/tb_camera_capture_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_control.sv
// SPI-domain camera control: op-code decode, shadowed crop window, capture FSM and response mux.
// Optional multi-frame burst / continuous capture is enabled by defining CAMERA_BURST_EN.
module camera_capture_control #(
    parameter int X_WIDTH         = 11,
    parameter int Y_WIDTH         = 10,
    parameter int ADDR_WIDTH      = 16,
    parameter int SIZE_WIDTH      = 20,
    parameter int METER_CHANNELS  = 3,
    parameter int X_START_DEFAULT = 0,
    parameter int X_END_DEFAULT   = 66,
    parameter int Y_START_DEFAULT = 0,
    parameter int Y_END_DEFAULT   = 66
) (
    input  logic                        clock_spi_in,
    input  logic                        mipi_byte_reset_n,
    input  logic [7:0]                  op_code_in,
    input  logic                        op_code_valid_in,
    input  logic [7:0]                  operand_in,
    input  logic                        operand_valid_in,
    input  logic [31:0]                 operand_count_in,
    output logic [7:0]                  response_out,
    output logic                        response_valid_out,
    input  logic                        frame_valid_in,
    output logic                        capture_active_out,
    output logic [X_WIDTH-1:0]          x_crop_start_out,
    output logic [X_WIDTH-1:0]          x_crop_end_out,
    output logic [Y_WIDTH-1:0]          y_crop_start_out,
    output logic [Y_WIDTH-1:0]          y_crop_end_out,
    output logic [X_WIDTH-1:0]          x_size_m1_out,
    output logic [Y_WIDTH-1:0]          y_size_m1_out,
    output logic [ADDR_WIDTH-1:0]       buffer_read_address_out,
    input  logic [7:0]                  buffer_read_data_in,
    input  logic [SIZE_WIDTH-1:0]       jpeg_size_in,
    output logic                        jpeg_size_clear_out,
    output logic                        jpeg_reset_out,
    input  logic [8*METER_CHANNELS-1:0] metering_in
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, WAIT = 2'd2, ACTIVE = 2'd3} state_t;

    localparam logic [7:0] OP_CAPTURE = 8'h20, OP_READ = 8'h22, OP_METER = 8'h25, OP_BURST = 8'h26,
                           OP_STOP = 8'h27, OP_CROP = 8'h28, OP_STATUS = 8'h29, OP_JCTRL = 8'h30,
                           OP_JSIZE = 8'h31;
    localparam logic [15:0] XS_D = 16'(X_START_DEFAULT), XE_D = 16'(X_END_DEFAULT);
    localparam logic [15:0] YS_D = 16'(Y_START_DEFAULT), YE_D = 16'(Y_END_DEFAULT);

    state_t             state;
    logic               op_d, opnd_d, fv_meta, fv_s;
    logic               op_rise, opnd_rise, cap_req, any_req, stop_req, req_cont;
    logic [7:0]         req_n, remaining, pend_n;
    logic               cont, pending, pend_cont, serve, error_q;
    logic [3:0]         frames;
    logic [7:0]         stg [8];
    logic [X_WIDTH-1:0] xs_n, xe_n, xs_p2;
    logic [Y_WIDTH-1:0] ys_n, ye_n, ys_p2;
    logic               commit_ok, resp_op;
    logic [7:0]         resp_mux, meter_byte, size_byte;
    logic [23:0]        size24;

    assign op_rise   = op_code_valid_in & ~op_d;
    assign opnd_rise = op_code_valid_in & operand_valid_in & ~opnd_d;
    assign cap_req   = op_rise && (op_code_in == OP_CAPTURE);

`ifdef CAMERA_BURST_EN
    logic burst_req;
    assign burst_req = opnd_rise && (op_code_in == OP_BURST) && (operand_count_in == 32'd0);
    assign stop_req  = op_rise && (op_code_in == OP_STOP);
    assign any_req   = cap_req | burst_req;
    assign req_n     = burst_req ? operand_in : 8'd1;
    assign req_cont  = burst_req && (operand_in == 8'd0);
`else
    assign stop_req  = 1'b0;
    assign any_req   = cap_req;
    assign req_n     = 8'd1;
    assign req_cont  = 1'b0;
`endif

    assign xs_n      = X_WIDTH'({stg[1], stg[0]});
    assign xe_n      = X_WIDTH'({stg[3], stg[2]});
    assign ys_n      = Y_WIDTH'({stg[5], stg[4]});
    assign ye_n      = Y_WIDTH'({stg[7], stg[6]});
    assign xs_p2     = xs_n + X_WIDTH'(2);
    assign ys_p2     = ys_n + Y_WIDTH'(2);
    assign commit_ok = (xe_n > xs_p2) && (ye_n > ys_p2);

    assign capture_active_out = (state == ACTIVE);

    always_ff @(posedge clock_spi_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            op_d <= 1'b0; opnd_d <= 1'b0; fv_meta <= 1'b0; fv_s <= 1'b0;
        end else begin
            op_d    <= op_code_valid_in;
            opnd_d  <= operand_valid_in;
            fv_meta <= frame_valid_in;
            fv_s    <= fv_meta;
        end
    end

    // A request that finds the FSM busy waits in a one-deep slot; it is loaded on IDLE entry
    // and `serve` then launches it from IDLE on the following cycle.
    always_ff @(posedge clock_spi_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            state     <= IDLE;
            remaining <= '0; cont <= 1'b0;
            pending   <= 1'b0; pend_n <= '0; pend_cont <= 1'b0; serve <= 1'b0;
            error_q   <= 1'b0; frames <= '0;
            x_crop_start_out <= X_WIDTH'(X_START_DEFAULT);
            x_crop_end_out   <= X_WIDTH'(X_END_DEFAULT);
            y_crop_start_out <= Y_WIDTH'(Y_START_DEFAULT);
            y_crop_end_out   <= Y_WIDTH'(Y_END_DEFAULT);
            x_size_m1_out    <= X_WIDTH'(X_END_DEFAULT - X_START_DEFAULT - 3);
            y_size_m1_out    <= Y_WIDTH'(Y_END_DEFAULT - Y_START_DEFAULT - 3);
        end else begin
            if (any_req && (state != IDLE) && !pending) begin
                pending <= 1'b1; pend_n <= req_n; pend_cont <= req_cont;
            end
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ARM; remaining <= req_n; cont <= req_cont; serve <= 1'b0;
                    end else if (serve) begin
                        state <= ARM; serve <= 1'b0;
                    end else if (pending) begin
                        remaining <= pend_n; cont <= pend_cont; pending <= 1'b0; serve <= 1'b1;
                    end
                end
                ARM: if (!fv_s) begin
                    state <= WAIT;
                    if (commit_ok) begin
                        x_crop_start_out <= xs_n; x_crop_end_out <= xe_n;
                        y_crop_start_out <= ys_n; y_crop_end_out <= ye_n;
                        x_size_m1_out    <= xe_n - xs_n - X_WIDTH'(3);
                        y_size_m1_out    <= ye_n - ys_n - Y_WIDTH'(3);
                        error_q          <= 1'b0;
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                WAIT: if (fv_s) state <= ACTIVE;
                ACTIVE: if (!fv_s) begin
                    if (frames != 4'hF) frames <= frames + 4'd1;
                    // remaining==0 only after a stop, so it must not wrap into another frame
                    if (stop_req || ((remaining < 8'd2) && !cont)) begin
                        state <= IDLE;
                        if (pending) begin
                            remaining <= pend_n; cont <= pend_cont; pending <= 1'b0; serve <= 1'b1;
                        end
                    end else begin
                        remaining <= remaining - 8'd1;
                        state     <= WAIT;
                    end
                end
            endcase
            if (any_req) frames <= '0;
            if (stop_req) begin
                remaining <= '0; cont <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock_spi_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            stg[0] <= XS_D[7:0]; stg[1] <= XS_D[15:8]; stg[2] <= XE_D[7:0]; stg[3] <= XE_D[15:8];
            stg[4] <= YS_D[7:0]; stg[5] <= YS_D[15:8]; stg[6] <= YE_D[7:0]; stg[7] <= YE_D[15:8];
            buffer_read_address_out <= '0;
            jpeg_size_clear_out     <= 1'b0;
            jpeg_reset_out          <= 1'b0;
        end else begin
            if (opnd_rise && (op_code_in == OP_CROP) && (operand_count_in < 32'd8))
                stg[operand_count_in[2:0]] <= operand_in;
            if (cap_req)
                buffer_read_address_out <= '0;
            else if (opnd_rise && (op_code_in == OP_READ))
                buffer_read_address_out <= buffer_read_address_out + ADDR_WIDTH'(1);
            if (opnd_rise && (op_code_in == OP_JCTRL)) begin
                jpeg_size_clear_out <= operand_in[1];
                jpeg_reset_out      <= operand_in[2];
            end
        end
    end

    always_comb begin
        meter_byte = 8'h00;
        for (int k = 0; k < METER_CHANNELS; k++)
            if (operand_count_in == 32'(k)) meter_byte = metering_in[8*k +: 8];
        size24 = 24'(jpeg_size_in);
        unique case (operand_count_in)
            32'd0:   size_byte = size24[7:0];
            32'd1:   size_byte = size24[15:8];
            32'd2:   size_byte = size24[23:16];
            default: size_byte = 8'h00;
        endcase
        resp_op  = 1'b1;
        resp_mux = 8'h00;
        unique case (op_code_in)
            OP_READ:   resp_mux = buffer_read_data_in;
            OP_METER:  resp_mux = meter_byte;
            OP_STATUS: resp_mux = {error_q, pending, state, frames};
            OP_JSIZE:  resp_mux = size_byte;
            default:   resp_op  = 1'b0;
        endcase
    end

    always_ff @(posedge clock_spi_in or negedge mipi_byte_reset_n) begin
        if (!mipi_byte_reset_n) begin
            response_out       <= 8'h00;
            response_valid_out <= 1'b0;
        end else begin
            response_valid_out <= op_code_valid_in && resp_op;
            response_out       <= (op_code_valid_in && resp_op) ? resp_mux : 8'h00;
        end
    end
endmodule

// File: tb/tb_camera_capture_control.sv
// Directed bench for camera_capture_control: response bytes go through an expected-value queue,
// crop/FSM/address behaviour is checked against constants derived from the requested stimulus.
module tb_camera_capture_control;
    localparam int AW = 8;

    logic          clock_spi_in = 1'b0;
    logic          mipi_byte_reset_n = 1'b0;
    logic [7:0]    op_code_in = 8'h00;
    logic          op_code_valid_in = 1'b0;
    logic [7:0]    operand_in = 8'h00;
    logic          operand_valid_in = 1'b0;
    logic [31:0]   operand_count_in = 32'd0;
    logic [7:0]    response_out;
    logic          response_valid_out;
    logic          frame_valid_in = 1'b0;
    logic          capture_active_out;
    logic [10:0]   x_crop_start_out, x_crop_end_out, x_size_m1_out;
    logic [9:0]    y_crop_start_out, y_crop_end_out, y_size_m1_out;
    logic [AW-1:0] buffer_read_address_out;
    logic [7:0]    buffer_read_data_in;
    logic [19:0]   jpeg_size_in = 20'hABCDE;
    logic          jpeg_size_clear_out, jpeg_reset_out;
    logic [23:0]   metering_in = 24'h332211;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    camera_capture_control #(.ADDR_WIDTH(AW)) dut (
        .clock_spi_in(clock_spi_in), .mipi_byte_reset_n(mipi_byte_reset_n),
        .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
        .operand_in(operand_in), .operand_valid_in(operand_valid_in),
        .operand_count_in(operand_count_in),
        .response_out(response_out), .response_valid_out(response_valid_out),
        .frame_valid_in(frame_valid_in), .capture_active_out(capture_active_out),
        .x_crop_start_out(x_crop_start_out), .x_crop_end_out(x_crop_end_out),
        .y_crop_start_out(y_crop_start_out), .y_crop_end_out(y_crop_end_out),
        .x_size_m1_out(x_size_m1_out), .y_size_m1_out(y_size_m1_out),
        .buffer_read_address_out(buffer_read_address_out), .buffer_read_data_in(buffer_read_data_in),
        .jpeg_size_in(jpeg_size_in), .jpeg_size_clear_out(jpeg_size_clear_out),
        .jpeg_reset_out(jpeg_reset_out), .metering_in(metering_in)
    );

    always #5 clock_spi_in = ~clock_spi_in;
    // image buffer stand-in: byte content is a fixed function of its address
    assign buffer_read_data_in = buffer_read_address_out ^ 8'h5A;

    task automatic tick();
        @(posedge clock_spi_in); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] v);
        exp_q.push_back(v); tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        logic [7:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty: observed %0h expected none", response_out);
        end else begin
            e = exp_q.pop_front(); t = tag_q.pop_front();
            assert ({response_valid_out, response_out} === {1'b1, e}) else begin
                failures++;
                $error("FAIL %s: observed vld=%0b data=%0h expected vld=1 data=%0h",
                       t, response_valid_out, response_out, e);
            end
        end
    endtask

    task automatic op_start(input logic [7:0] code);
        op_code_in = code; op_code_valid_in = 1'b1; tick();
    endtask

    task automatic op_end();
        op_code_valid_in = 1'b0; operand_valid_in = 1'b0; tick();
    endtask

    task automatic pulse(input logic [7:0] b, input int k);
        operand_in = b; operand_count_in = 32'(k); operand_valid_in = 1'b1; tick();
        operand_valid_in = 1'b0; tick();
    endtask

    task automatic stage(input int xs, input int xe, input int ys, input int ye);
        logic [15:0] v [4];
        v[0] = 16'(xs); v[1] = 16'(xe); v[2] = 16'(ys); v[3] = 16'(ye);
        op_start(8'h28);
        for (int i = 0; i < 4; i++) begin
            pulse(v[i][7:0], 2*i);
            pulse(v[i][15:8], 2*i + 1);
        end
        op_end();
    endtask

    task automatic capture();
        op_start(8'h20); op_end();
    endtask

    task automatic read_status(input string tag, input logic [7:0] e);
        operand_count_in = 32'd0;
        sb_push(tag, e);
        op_start(8'h29); sb_check(); op_end();
    endtask

    // frame with capture expected; activity must follow each fv edge by exactly 3 cycles
    task automatic frame_chk(input string tag);
        frame_valid_in = 1'b1; tick(); tick();
        chk({tag, "_rise2"}, 32'(capture_active_out), 0);
        tick();
        chk({tag, "_rise3"}, 32'(capture_active_out), 1);
        repeat (3) tick();
        frame_valid_in = 1'b0; tick(); tick();
        chk({tag, "_fall2"}, 32'(capture_active_out), 1);
        tick();
        chk({tag, "_fall3"}, 32'(capture_active_out), 0);
        repeat (2) tick();
    endtask

    task automatic frame_ignored(input string tag);
        frame_valid_in = 1'b1; repeat (4) tick();
        chk(tag, 32'(capture_active_out), 0);
        frame_valid_in = 1'b0; repeat (4) tick();
    endtask

    initial begin
        logic [7:0] exp_sz [4];
        logic [7:0] exp_mt [4];
        exp_sz[0] = 8'hDE; exp_sz[1] = 8'hBC; exp_sz[2] = 8'h0A; exp_sz[3] = 8'h00;
        exp_mt[0] = 8'h11; exp_mt[1] = 8'h22; exp_mt[2] = 8'h33; exp_mt[3] = 8'h00;

        repeat (3) tick();
        mipi_byte_reset_n = 1'b1; tick();
        chk("rst_x_size", 32'(x_size_m1_out), 63);
        chk("rst_y_size", 32'(y_size_m1_out), 63);
        chk("rst_x_end", 32'(x_crop_end_out), 66);
        chk("rst_y_start", 32'(y_crop_start_out), 0);
        chk("rst_active", 32'(capture_active_out), 0);
        chk("rst_resp_vld", 32'(response_valid_out), 0);
        chk("rst_addr", 32'(buffer_read_address_out), 0);
        chk("rst_jpeg_ctl", {30'd0, jpeg_size_clear_out, jpeg_reset_out}, 0);

        // JPEG size bytes, then metering channels, one operand index per cycle
        op_code_in = 8'h31; op_code_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            operand_count_in = 32'(k); sb_push("jsize", exp_sz[k]); tick(); sb_check();
        end
        op_end();
        chk("jsize_vld_fall", 32'(response_valid_out), 0);
        op_code_in = 8'h25; op_code_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            operand_count_in = 32'(k); sb_push("meter", exp_mt[k]); tick(); sb_check();
        end
        op_end();

        op_start(8'h30); pulse(8'h06, 0);
        chk("jctl_a", {30'd0, jpeg_size_clear_out, jpeg_reset_out}, 3);
        pulse(8'h04, 1);
        chk("jctl_b", {30'd0, jpeg_size_clear_out, jpeg_reset_out}, 1);
        op_end();

        // valid crop committed in ARM, then one frame
        stage(100, 300, 0, 66);
        op_start(8'h20);
        chk("crop_before_commit", 32'(x_crop_start_out), 0);
        op_end();
        chk("crop_xs", 32'(x_crop_start_out), 100);
        chk("crop_xe", 32'(x_crop_end_out), 300);
        chk("crop_xsize", 32'(x_size_m1_out), 197);
        frame_chk("f1");
        read_status("st_after_f1", 8'h01);

        // degenerate window rejected
        stage(50, 51, 0, 66);
        capture();
        chk("rej_xs", 32'(x_crop_start_out), 100);
        chk("rej_xe", 32'(x_crop_end_out), 300);
        chk("rej_xsize", 32'(x_size_m1_out), 197);
        read_status("st_rejected", 8'hA0);
        frame_chk("f_rej");

        // read address wrap with ADDR_WIDTH=8
        operand_count_in = 32'd0;
        sb_push("rd_first", 8'h5A);
        op_start(8'h22); sb_check();
        for (int i = 0; i < 254; i++) pulse(8'h00, i);
        chk("addr_fe", 32'(buffer_read_address_out), 32'hFE);
        pulse(8'h00, 254); chk("addr_ff", 32'(buffer_read_address_out), 32'hFF);
        pulse(8'h00, 255); chk("addr_00", 32'(buffer_read_address_out), 32'h00);
        pulse(8'h00, 256); chk("addr_01", 32'(buffer_read_address_out), 32'h01);
        sb_push("rd_data", 8'h5B); sb_check();
        op_end();

        // requests during ACTIVE: one pending, the third dropped
        stage(10, 20, 0, 66);
        capture();
        chk("addr_cleared", 32'(buffer_read_address_out), 0);
        chk("crop_xsize_b", 32'(x_size_m1_out), 7);
        read_status("st_err_clear", 8'h20);
        frame_valid_in = 1'b1; repeat (3) tick();
        chk("pend_active", 32'(capture_active_out), 1);
        capture(); capture();
        read_status("st_pending", 8'h70);
        frame_valid_in = 1'b0; repeat (3) tick();
        chk("pend_f1_end", 32'(capture_active_out), 0);
        read_status("st_pend_idle", 8'h01);
        frame_chk("pend_f2");
        read_status("st_two_frames", 8'h02);
        frame_ignored("no_third_frame");

`ifdef CAMERA_BURST_EN
        op_start(8'h26); pulse(8'h03, 0); op_end();
        frame_chk("burst_f1"); frame_chk("burst_f2"); frame_chk("burst_f3");
        frame_ignored("burst_done");
        read_status("st_burst", 8'h03);
        op_start(8'h26); pulse(8'h00, 0); op_end();
        frame_chk("cont_f1"); frame_chk("cont_f2");
        frame_valid_in = 1'b1; repeat (3) tick();
        chk("cont_f3_active", 32'(capture_active_out), 1);
        op_start(8'h27); op_end();
        chk("stop_no_truncate", 32'(capture_active_out), 1);
        frame_valid_in = 1'b0; repeat (3) tick();
        chk("stop_end", 32'(capture_active_out), 0);
        frame_ignored("stop_idle");
`endif

        // asynchronous reset mid-frame
        stage(200, 400, 5, 50);
        capture();
        frame_valid_in = 1'b1; repeat (3) tick();
        chk("arst_pre_active", 32'(capture_active_out), 1);
        chk("arst_pre_xs", 32'(x_crop_start_out), 200);
        #2 mipi_byte_reset_n = 1'b0; #1;
        chk("arst_active", 32'(capture_active_out), 0);
        chk("arst_xs", 32'(x_crop_start_out), 0);
        chk("arst_ysize", 32'(y_size_m1_out), 63);
        frame_valid_in = 1'b0;
        tick(); mipi_byte_reset_n = 1'b1; tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $error("FAIL sb_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
